// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner and its key-code consumers.
// Row strobes, FSM/frame enums, code mapping and the seven-segment glyph table.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } key_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_kind_t;

    localparam logic [3:0] ROW_STROBE_0 = 4'b1110;
    localparam logic [3:0] ROW_STROBE_1 = 4'b1101;
    localparam logic [3:0] ROW_STROBE_2 = 4'b1011;
    localparam logic [3:0] ROW_STROBE_3 = 4'b0111;

    // Segment order {g,f,e,d,c,b,a}, active high, indexed by key code.
    localparam logic [6:0] SEG7_MAP [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [3:0] row_strobe(input logic [1:0] slot);
        logic [3:0] strobe;
        case (slot)
            2'd0:    strobe = ROW_STROBE_0;
            2'd1:    strobe = ROW_STROBE_1;
            2'd2:    strobe = ROW_STROBE_2;
            default: strobe = ROW_STROBE_3;
        endcase
        return strobe;
    endfunction

    // Row 3 col 3 wraps to code 0, matching the printed keypad legend.
    function automatic logic [3:0] key_code_of(input logic [1:0] r, input logic [1:0] c);
        return {r, c} + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_frame_capture.sv
// Row-strobe rotation, slot divider and per-slot column sampling.
// Summarises each 4-slot frame as NONE / SINGLE(code) / MULTI on its last cycle.
module keypad_frame_capture
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    output logic        frame_done,
    output frame_kind_t frame_kind,
    output logic [3:0]  frame_code
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div;
    logic [1:0]    slot;
    logic [1:0]    slot_next;
    logic          sample;
    logic [1:0]    low_acc;
    logic [3:0]    code_acc;
    logic [1:0]    sample_lows;
    logic [1:0]    col_idx;
    logic [1:0]    low_total;
    logic [3:0]    code_total;
    logic [2:0]    low_sum;
    int            lows;

    assign sample    = (div == DIV_LAST);
    assign slot_next = slot + 2'd1;

    always_comb begin
        lows        = $countones(~col);
        sample_lows = (lows >= 2) ? 2'd2 : 2'(lows);
        col_idx     = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col[i]) col_idx = 2'(i);
        end
        // Low-bit count saturates at 2: anything beyond one is already MULTI.
        low_sum    = {1'b0, low_acc} + {1'b0, sample_lows};
        low_total  = (low_sum >= 3'd2) ? 2'd2 : low_sum[1:0];
        code_total = (low_acc != 2'd0) ? code_acc : key_code_of(slot, col_idx);
    end

    always_comb begin
        frame_done = sample && (slot == 2'd3);
        frame_code = code_total;
        case (low_total)
            2'd0:    frame_kind = NONE;
            2'd1:    frame_kind = SINGLE;
            default: frame_kind = MULTI;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div      <= '0;
            slot     <= 2'd0;
            row      <= ROW_STROBE_0;
            low_acc  <= 2'd0;
            code_acc <= 4'd0;
        end else if (sample) begin
            div  <= '0;
            slot <= slot_next;
            row  <= row_strobe(slot_next);
            if (slot == 2'd3) begin
                low_acc  <= 2'd0;
                code_acc <= 4'd0;
            end else begin
                low_acc  <= low_total;
                code_acc <= code_total;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan controller: frame-level debounce FSM and one-deep key event register.
// state    | meaning
// IDLE     | no key confirmed; waiting for a SINGLE frame
// PRESS_DB | candidate key seen in cnt consecutive SINGLE frames
// HELD     | key confirmed and reported; waiting for a NONE frame
// REL_DB   | key released for cnt consecutive NONE frames
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down,
    output logic       overrun
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic        frame_done;
    frame_kind_t frame_kind;
    logic [3:0]  frame_code;

    key_state_t  state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]  cand, cand_n;
    logic        emit;

    keypad_frame_capture #(
        .SCAN_DIV (SCAN_DIV)
    ) u_capture (
        .clk        (clk),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .frame_done (frame_done),
        .frame_kind (frame_kind),
        .frame_code (frame_code)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        emit    = 1'b0;
        cnt_inc = (cnt == DB_LAST) ? cnt : cnt + 1'b1;
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (frame_kind == SINGLE) begin
                        cand_n = frame_code;
                        if (CNT_ONE >= DB_LAST) begin
                            emit    = 1'b1;
                            state_n = HELD;
                            cnt_n   = '0;
                        end else begin
                            state_n = PRESS_DB;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                PRESS_DB: begin
                    if (frame_kind == SINGLE && frame_code == cand) begin
                        if (cnt_inc >= DB_LAST) begin
                            emit    = 1'b1;
                            state_n = HELD;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else if (frame_kind == SINGLE) begin
                        // A different key restarts the count rather than aborting.
                        cand_n = frame_code;
                        cnt_n  = CNT_ONE;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                HELD: begin
                    if (frame_kind == NONE) begin
                        if (CNT_ONE >= DB_LAST) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
                            state_n = REL_DB;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                REL_DB: begin
                    if (frame_kind == NONE) begin
                        if (cnt_inc >= DB_LAST) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = HELD;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign key_down = (state == HELD) || (state == REL_DB);

    // A press that finds the slot still occupied is dropped; the old event wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (emit) begin
                if (!key_valid || key_ready) begin
                    key_code  <= frame_code;
                    key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule
